multi_channel_pulse_shaper: RTL
===============================

Name: multi_channel_pulse_shaper

Overview:
- N_CH-channel successor to the single-channel detector pulse shaper.
- Synchronises each asynchronous photon-detector input into the 500 MHz clk domain and detects rising edges.
- On each accepted edge, emits a fixed-width pulse followed by a dead time; both durations are runtime-programmable.
- Counts edges lost during lockout, per channel. Sits between the detector inputs and the time-correlation/coincidence counters.

Parameters:
- N_CH, 4, number of independent channels.
- CNT_W, 8, width of the pulse-width and dead-time fields and of the per-channel timer.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; legal range is 2 to 4.
- DROP_W, 16, width of each per-channel dropped-event counter.

Ports:
- clk  in  1  system clock, 500 MHz.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global arm; when low, all channels are held IDLE.
- pulse_width  in  CNT_W  pulse high time in clk cycles; 0 is treated as 1.
- dead_time  in  CNT_W  lockout after the pulse, in clk cycles; 0 is allowed.
- drop_clr  in  1  single-cycle clear of all drop counters.
- channel  in  N_CH  asynchronous detector inputs.
- pulse  out  N_CH  shaped output pulses, registered.
- busy  out  N_CH  high while a channel is in PULSE or DEAD, registered.
- drop_cnt  out  N_CH*DROP_W  per-channel dropped-edge counters; channel i occupies bits [i*DROP_W +: DROP_W].

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pulse, busy and drop_cnt go to 0; all FSMs go to IDLE; timers go to 0.
  - Synchroniser chains and the edge-detect "prev" register go to 1, so a level already high at reset release does not produce a pulse.
  - Reset asserted mid-pulse or mid-dead-time aborts immediately; pulse is 0 on the next cycle.
- Synchroniser: channel[i] passes through SYNC_STAGES flops to give s[i]. A prev register holds s[i] from the previous cycle. Edge condition: e[i] = s[i] & ~prev[i].
- Per-channel FSM, with states IDLE, PULSE and DEAD:
  - IDLE: if e[i] and enable are both high, latch W = max(pulse_width, 1) and D = dead_time, load the timer with W-1, and go to PULSE with pulse=1 and busy=1.
  - PULSE: pulse=1. When the timer reaches 0, go to DEAD with the timer loaded to D-1 if D>0; otherwise go to IDLE. pulse falls on that edge.
  - DEAD: pulse=0, busy=1. When the timer reaches 0, go to IDLE with busy=0.
  - Config is sampled only at the trigger; changes mid-pulse do not affect the pulse in flight.
- Latency: if the clk edge k is the first to sample channel high, pulse rises at edge k+SYNC_STAGES and stays high for exactly W cycles. The channel accepts a new edge in the first cycle after exactly W+D cycles of busy.
- Acceptance: an edge is accepted only if the FSM is IDLE at that clk edge. An edge coincident with the last DEAD cycle is dropped. Each input rising edge counts once: it is either accepted or dropped, never both.
- Drop counter:
  - Increments by 1 on every e[i] seen in PULSE or DEAD, and on every e[i] seen while enable=0.
  - Saturates at 2^DROP_W-1 with no wrap.
  - drop_clr and a drop in the same cycle give a result of 1. drop_clr alone gives 0.
- enable deasserted: channels in PULSE or DEAD go to IDLE on the next edge with pulse=0 and busy=0. drop_cnt is retained.
- Channels are fully independent; simultaneous edges on all channels each produce their own pulse in the same cycle.
- Inputs held high produce one pulse per rising edge, never a retrigger on level.

Test Plan:
- Single edge: SYNC_STAGES=2, pulse_width=1, dead_time=30; channel[0] rises before edge k → pulse[0] high only in the cycle after edge k+2, busy[0] high for 31 cycles, drop_cnt[0]=0.
- Lockout drop: pulse_width=4, dead_time=10; second rising edge on channel[1] arrives 8 cycles after the first → exactly one pulse of 4 cycles, drop_cnt[1]=1. A third edge 15 cycles after the first → second pulse, drop_cnt[1] stays 1.
- Boundary: pulse_width=0, dead_time=0; edges spaced 1 cycle after busy falls → every edge produces a 1-cycle pulse. An edge landing in the final DEAD cycle with dead_time=5 is dropped and counted.
- Saturation and clear: DROP_W=4; force 20 drops → drop_cnt=15. drop_clr together with a drop → 1. drop_clr alone → 0.
- Reset and enable: assert rst during PULSE → pulse=0 and busy=0 next cycle. Hold channel high through reset release → no pulse. enable=0 with 3 edges → no pulses, drop_cnt=3.
- Multi-channel: simultaneous edges on all 4 channels with pulse_width=3 → four identical 3-cycle pulses in the same cycles. Changing pulse_width to 7 mid-pulse leaves the in-flight width at 3.

Source files
------------

// File: rtl/multi_channel_pulse_shaper.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_pulse_shaper
// Purpose  : N_CH independent detector-input shapers. Each channel
//            synchronises its asynchronous input, detects rising edges, emits
//            a programmable-width pulse followed by a programmable dead time,
//            and counts edges lost while locked out or disarmed.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module multi_channel_pulse_shaper #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,   // legal range 2..4
    parameter int DROP_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [CNT_W-1:0]       pulse_width,
    input  logic [CNT_W-1:0]       dead_time,
    input  logic                   drop_clr,
    input  logic [N_CH-1:0]        channel,
    output logic [N_CH-1:0]        pulse,
    output logic [N_CH-1:0]        busy,
    output logic [N_CH*DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_DEAD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  C_TMR_ONE  = CNT_W'(1);
    localparam logic [DROP_W-1:0] C_DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] C_DROP_MAX = '1;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_prev;
            logic                   w_sync_out;
            logic                   w_edge;
            logic                   w_drop;
            state_t                 r_state;
            state_t                 w_state_nxt;
            logic [CNT_W-1:0]       r_timer;
            logic [CNT_W-1:0]       w_timer_nxt;
            logic [CNT_W-1:0]       r_dead;
            logic [CNT_W-1:0]       w_dead_nxt;
            logic                   r_pulse;
            logic                   w_pulse_nxt;
            logic                   r_busy;
            logic                   w_busy_nxt;
            logic [DROP_W-1:0]      r_drop;

            assign w_sync_out = r_sync[SYNC_STAGES-1];
            assign w_edge     = w_sync_out & ~r_prev;
            // An edge is lost whenever the channel cannot accept it this cycle.
            assign w_drop     = w_edge & ~((r_state == S_IDLE) & enable);

            // Input synchroniser and edge history; reset to 1 so a level already
            // high when reset releases is not seen as an edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '1;
                    r_prev <= 1'b1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], channel[gi]};
                    r_prev <= w_sync_out;
                end
            end

            // FSM state, timer, latched dead time and registered outputs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_dead  <= '0;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_timer <= w_timer_nxt;
                    r_dead  <= w_dead_nxt;
                    r_pulse <= w_pulse_nxt;
                    r_busy  <= w_busy_nxt;
                end
            end

            // Next-state logic; width and dead time are captured only at trigger.
            always_comb begin
                w_state_nxt = r_state;
                w_timer_nxt = r_timer;
                w_dead_nxt  = r_dead;
                w_pulse_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (enable && w_edge) begin
                            w_state_nxt = S_PULSE;
                            // A programmed width of 0 behaves as 1.
                            w_timer_nxt = (pulse_width == '0) ? '0 : (pulse_width - C_TMR_ONE);
                            w_dead_nxt  = dead_time;
                            w_pulse_nxt = 1'b1;
                            w_busy_nxt  = 1'b1;
                        end
                    end
                    S_PULSE: begin
                        if (r_timer == '0) begin
                            if (r_dead != '0) begin
                                w_state_nxt = S_DEAD;
                                w_timer_nxt = r_dead - C_TMR_ONE;
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_timer_nxt = r_timer - C_TMR_ONE;
                            w_pulse_nxt = 1'b1;
                            w_busy_nxt  = 1'b1;
                        end
                    end
                    S_DEAD: begin
                        if (r_timer == '0) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_timer_nxt = r_timer - C_TMR_ONE;
                            w_busy_nxt  = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_timer_nxt = '0;
                    end
                endcase
                // Disarming aborts any pulse or lockout in progress.
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                    w_pulse_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            end

            // Saturating drop counter; a clear coincident with a drop leaves 1.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_drop <= '0;
                end else if (drop_clr) begin
                    r_drop <= w_drop ? C_DROP_ONE : '0;
                end else if (w_drop && (r_drop != C_DROP_MAX)) begin
                    r_drop <= r_drop + C_DROP_ONE;
                end
            end

            assign pulse[gi]                     = r_pulse;
            assign busy[gi]                      = r_busy;
            assign drop_cnt[gi*DROP_W +: DROP_W] = r_drop;
        end
    endgenerate

endmodule
`default_nettype wire
